// File: rtl/input_stream_buffer_controller.sv
// rtl/input_stream_buffer_controller.sv - circular row buffer sequencer for the input memory
// Packs streamed elements lane by lane into rows and pops committed rows with one-cycle read latency.
module input_stream_buffer_controller #(
  parameter int INPUT_WORD_BIT_WIDTH = 64,
  parameter int INPUT_ROWS           = 32,
  parameter int ELEMENT_BIT_WIDTH    = 4,
  localparam int ELEMENTS_PER_WORD   = INPUT_WORD_BIT_WIDTH / ELEMENT_BIT_WIDTH,
  localparam int INPUT_ADDRESS_WIDTH = $clog2(INPUT_ROWS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            spi_active,
  input  logic [ELEMENT_BIT_WIDTH-1:0]    in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            rd_req,
  output logic                            rd_ready,
  output logic                            rd_valid,
  output logic [INPUT_ADDRESS_WIDTH:0]    occupancy,
  output logic                            full,
  output logic                            empty,
  output logic                            input_control_write_enable,
  output logic [INPUT_ADDRESS_WIDTH-1:0]  input_control_address_write,
  output logic [INPUT_WORD_BIT_WIDTH-1:0] input_control_data_in,
  output logic [INPUT_WORD_BIT_WIDTH-1:0] input_control_mask,
  output logic                            input_control_read_enable,
  output logic [INPUT_ADDRESS_WIDTH-1:0]  input_control_address_read
);

  localparam int LANE_W = (ELEMENTS_PER_WORD > 1) ? $clog2(ELEMENTS_PER_WORD) : 1;
  localparam logic [INPUT_ADDRESS_WIDTH:0]   ROWS_OCC  = (INPUT_ADDRESS_WIDTH + 1)'(INPUT_ROWS);
  localparam logic [INPUT_ADDRESS_WIDTH-1:0] LAST_ROW  = INPUT_ADDRESS_WIDTH'(INPUT_ROWS - 1);
  localparam logic [LANE_W-1:0]              LAST_LANE = LANE_W'(ELEMENTS_PER_WORD - 1);

  logic [INPUT_ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [INPUT_ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0]              lane_q, lane_d;
  logic [INPUT_ADDRESS_WIDTH:0]   occ_q, occ_d;
  logic                           rd_valid_q, rd_valid_d;

  logic wr_fire;
  logic rd_fire;
  logic commit;

  assign full     = (occ_q == ROWS_OCC);
  assign empty    = (occ_q == '0);
  assign in_ready = !spi_active && !flush && !full;
  assign rd_ready = !spi_active && !flush && !empty;
  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = rd_req && rd_ready;
  assign commit   = wr_fire && (lane_q == LAST_LANE);

  assign occupancy = occ_q;
  assign rd_valid  = rd_valid_q;

  assign input_control_write_enable  = wr_fire;
  assign input_control_address_write = wr_ptr_q;
  assign input_control_read_enable   = rd_fire;
  assign input_control_address_read  = rd_ptr_q;

  // Lane placement: element and mask land only in the current lane's bit slice.
  always_comb begin
    input_control_data_in = '0;
    input_control_mask    = '0;
    for (int l = 0; l < ELEMENTS_PER_WORD; l++) begin
      if (lane_q == LANE_W'(l)) begin
        input_control_data_in[l*ELEMENT_BIT_WIDTH +: ELEMENT_BIT_WIDTH] = in_data;
        input_control_mask[l*ELEMENT_BIT_WIDTH +: ELEMENT_BIT_WIDTH]    = '1;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lane_d     = lane_q;
    occ_d      = occ_q;
    rd_valid_d = rd_fire;

    if (wr_fire) begin
      if (commit) begin
        lane_d   = '0;
        wr_ptr_d = (wr_ptr_q == LAST_ROW) ? '0 : wr_ptr_q + 1'b1;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end

    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == LAST_ROW) ? '0 : rd_ptr_q + 1'b1;
    end

    // A commit and a pop in the same cycle cancel in the row count.
    case ({commit, rd_fire})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      lane_d     = '0;
      occ_d      = '0;
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lane_q     <= '0;
      occ_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lane_q     <= lane_d;
      occ_q      <= occ_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule
